// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge
// Bridges asynchronous Z80 memory strobes into single-clock read/write
// requests toward port A of the GPU RAM mux. Only accesses inside
// [MEM_BASE, MEM_BASE+MEM_SIZE) are forwarded. Exactly one request is
// issued per Z80 bus cycle. A read that is not answered within
// TIMEOUT_CYCLES clocks returns 8'hFF and sets a sticky error flag.
//
// Optional feature: define Z80_BRIDGE_WAIT_EN to drive z80_wait_n low while
// an in-window read is still in flight. The default build ties it high.
module z80_bus_bridge #(
  parameter logic [21:0] MEM_BASE       = 22'h0C0000,
  parameter logic [21:0] MEM_SIZE       = 22'h008000,
  parameter int unsigned REQ_HOLD       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        z80_mreq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [21:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  output logic        z80_wait_n,
  output logic        rd_req,
  output logic        wr_ena,
  output logic [19:0] address,
  output logic [7:0]  data_out,
  input  logic        rd_rdy,
  input  logic [7:0]  data_in,
  output logic        timeout_err
);

  localparam int HOLD_W = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REQ_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  // Window end computed one bit wider so a window touching the top of the
  // 22-bit space cannot wrap.
  localparam logic [22:0] WIN_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_HOLD = 3'd3,
    WR_REQ  = 3'd4,
    CYC_END = 3'd5
  } state_t;

  state_t state_r;
  state_t state_d;

  logic mreq_s1_r, mreq_s2_r;
  logic rd_s1_r,   rd_s2_r;
  logic wr_s1_r,   wr_s2_r;

  logic [HOLD_W-1:0] hold_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;

  logic        hit_s;
  logic        start_s;
  logic        rd_accept_s;
  logic        timeout_s;
  logic        hold_done_s;
  logic        to_done_s;

  logic [19:0] address_r;
  logic [7:0]  data_out_r;
  logic [7:0]  z80_data_out_r;
  logic        z80_data_oe_r;
  logic        rd_req_r;
  logic        wr_ena_r;
  logic        timeout_err_r;

  // Raw address decode; the Z80 holds the address stable while the strobes settle.
  assign hit_s = ({1'b0, z80_addr} >= {1'b0, MEM_BASE}) &&
                 ({1'b0, z80_addr} <  WIN_END);

  // Two-flop synchronisers for the asynchronous strobes, preset inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mreq_s1_r <= 1'b1;
      mreq_s2_r <= 1'b1;
      rd_s1_r   <= 1'b1;
      rd_s2_r   <= 1'b1;
      wr_s1_r   <= 1'b1;
      wr_s2_r   <= 1'b1;
    end else begin
      mreq_s1_r <= z80_mreq_n;
      mreq_s2_r <= mreq_s1_r;
      rd_s1_r   <= z80_rd_n;
      rd_s2_r   <= rd_s1_r;
      wr_s1_r   <= z80_wr_n;
      wr_s2_r   <= wr_s1_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Next-state decode and per-clock datapath strobes.
  always_comb begin
    state_d     = state_r;
    start_s     = 1'b0;
    rd_accept_s = 1'b0;
    timeout_s   = 1'b0;
    hold_done_s = (hold_cnt_r == HOLD_LAST);
    to_done_s   = (to_cnt_r == TO_LAST);
    case (state_r)
      IDLE: begin
        if (!mreq_s2_r && hit_s) begin
          if (!rd_s2_r) begin
            // Read takes priority when both strobes appear low.
            state_d = RD_REQ;
            start_s = 1'b1;
          end else if (!wr_s2_r) begin
            state_d = WR_REQ;
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (rd_rdy) begin
          state_d     = RD_HOLD;
          rd_accept_s = 1'b1;
        end else if (to_done_s) begin
          state_d   = RD_HOLD;
          timeout_s = 1'b1;
        end else if (hold_done_s) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (rd_rdy) begin
          state_d     = RD_HOLD;
          rd_accept_s = 1'b1;
        end else if (to_done_s) begin
          state_d   = RD_HOLD;
          timeout_s = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (hold_done_s) begin
          state_d = CYC_END;
        end else begin
          state_d = WR_REQ;
        end
      end
      RD_HOLD, CYC_END: begin
        // Stay parked until the Z80 ends its bus cycle.
        if (mreq_s2_r) begin
          state_d = IDLE;
        end else begin
          state_d = state_r;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request-hold and read-timeout counters, both restarted when a cycle begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_r <= '0;
      to_cnt_r   <= '0;
    end else if (start_s) begin
      hold_cnt_r <= '0;
      to_cnt_r   <= '0;
    end else begin
      if ((state_r == RD_REQ) || (state_r == WR_REQ)) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      if ((state_r == RD_REQ) || (state_r == RD_WAIT)) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  // Address/write-data capture at cycle start; read data or timeout fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address_r      <= 20'h00000;
      data_out_r     <= 8'h00;
      z80_data_out_r <= 8'h00;
      timeout_err_r  <= 1'b0;
    end else begin
      if (start_s) begin
        address_r  <= 20'(z80_addr - MEM_BASE);
        data_out_r <= z80_data_in;
      end else begin
        address_r  <= address_r;
        data_out_r <= data_out_r;
      end
      if (rd_accept_s) begin
        z80_data_out_r <= data_in;
      end else if (timeout_s) begin
        z80_data_out_r <= 8'hFF;
        timeout_err_r  <= 1'b1;
      end else begin
        z80_data_out_r <= z80_data_out_r;
      end
    end
  end

  // Registered strobes, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_req_r      <= 1'b0;
      wr_ena_r      <= 1'b0;
      z80_data_oe_r <= 1'b0;
    end else begin
      rd_req_r      <= (state_d == RD_REQ);
      wr_ena_r      <= (state_d == WR_REQ);
      // rd_s1_r is the value the synced rd takes on this same edge.
      z80_data_oe_r <= (state_d == RD_HOLD) && !rd_s1_r;
    end
  end

`ifdef Z80_BRIDGE_WAIT_EN
  // Stretch the Z80 cycle while an in-window read has not yet been answered.
  assign z80_wait_n = ~(reset && !z80_mreq_n && !z80_rd_n && hit_s &&
                        (state_r != RD_HOLD));
`else
  assign z80_wait_n = 1'b1;
`endif

  assign rd_req       = rd_req_r;
  assign wr_ena       = wr_ena_r;
  assign address      = address_r;
  assign data_out     = data_out_r;
  assign z80_data_out = z80_data_out_r;
  assign z80_data_oe  = z80_data_oe_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Randomised self-checking bench for z80_bus_bridge. A transaction-level
// model predicts address/data captures, request lengths, read data, timeout
// flag and output-enable from the window and timing rules.
module tb_z80_bus_bridge;

  localparam logic [21:0] BASE = 22'h0C0000;
  localparam logic [21:0] SIZE = 22'h008000;
  localparam int HOLD = 2;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        z80_mreq_n = 1'b1;
  logic        z80_rd_n = 1'b1;
  logic        z80_wr_n = 1'b1;
  logic [21:0] z80_addr = 22'h0;
  logic [7:0]  z80_data_in = 8'h00;
  logic [7:0]  z80_data_out;
  logic        z80_data_oe;
  logic        z80_wait_n;
  logic        rd_req;
  logic        wr_ena;
  logic [19:0] address;
  logic [7:0]  mux_wdata;
  logic        rd_rdy = 1'b0;
  logic [7:0]  mux_rdata = 8'h00;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [19:0] exp_addr  = 20'h0;
  logic [7:0]  exp_wdata = 8'h00;
  logic [7:0]  exp_rdata = 8'h00;
  logic        exp_terr  = 1'b0;

  z80_bus_bridge #(
    .MEM_BASE(BASE), .MEM_SIZE(SIZE), .REQ_HOLD(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_addr(z80_addr), .z80_data_in(z80_data_in),
    .z80_data_out(z80_data_out), .z80_data_oe(z80_data_oe),
    .z80_wait_n(z80_wait_n), .rd_req(rd_req), .wr_ena(wr_ena),
    .address(address), .data_out(mux_wdata), .rd_rdy(rd_rdy),
    .data_in(mux_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [21:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + int'(SIZE));
  endfunction

  task automatic release_bus();
    @(negedge clk);
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    z80_wr_n   = 1'b1;
    rd_rdy     = 1'b0;
    repeat (4) @(negedge clk);
    check("oe_after_release", z80_data_oe, 1'b0);
  endtask

  // Read cycle: rdy pulse d clocks after rd_req is first seen; optional
  // second pulse two clocks later carrying different data.
  task automatic do_read(input logic [21:0] a, input logic [7:0] wd, input int d,
                         input logic [7:0] rd1, input bit second,
                         input logic [7:0] rd2, input bit both);
    bit hit;
    bit acc;
    int req_clks;
    int rise;
    int exp_clks;
    hit = in_win(a);
    req_clks = 0;
    rise = -1;
    @(negedge clk);
    z80_addr    = a;
    z80_data_in = wd;
    z80_mreq_n  = 1'b0;
    z80_rd_n    = 1'b0;
    z80_wr_n    = both ? 1'b0 : 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd_rdy = 1'b0;
      if (rd_req) begin
        req_clks++;
        if (rise < 0) begin
          rise = i;
          check("wait_during_req", z80_wait_n,
`ifdef Z80_BRIDGE_WAIT_EN
                1'b0
`else
                1'b1
`endif
               );
        end
      end
      if (wr_ena) check("no_wr_on_read", wr_ena, 1'b0);
      if (rise >= 0 && i == rise + d) begin
        rd_rdy = 1'b1;
        mux_rdata = rd1;
      end
      if (second && rise >= 0 && i == rise + d + 2) begin
        rd_rdy = 1'b1;
        mux_rdata = rd2;
      end
    end
    rd_rdy = 1'b0;
    if (hit) begin
      acc = (d + 1 <= TMO);
      exp_clks = acc ? ((d + 1 < HOLD) ? d + 1 : HOLD) : HOLD;
      exp_addr  = 20'(a - BASE);
      exp_wdata = wd;
      exp_rdata = acc ? rd1 : 8'hFF;
      if (!acc) exp_terr = 1'b1;
    end else begin
      exp_clks = 0;
    end
    check("rd_req_clocks", req_clks, exp_clks);
    check("rd_address", address, exp_addr);
    check("rd_data_out", mux_wdata, exp_wdata);
    check("rd_z80_data", z80_data_out, exp_rdata);
    check("timeout_err", timeout_err, exp_terr);
    check("rd_oe", z80_data_oe, hit);
    check("wait_released", z80_wait_n, 1'b1);
    release_bus();
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] wd);
    bit hit;
    int wr_clks;
    int rd_clks;
    hit = in_win(a);
    wr_clks = 0;
    rd_clks = 0;
    @(negedge clk);
    z80_addr    = a;
    z80_data_in = wd;
    z80_mreq_n  = 1'b0;
    z80_wr_n    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ena) wr_clks++;
      if (rd_req) rd_clks++;
    end
    if (hit) begin
      exp_addr  = 20'(a - BASE);
      exp_wdata = wd;
    end
    check("wr_ena_clocks", wr_clks, hit ? HOLD : 0);
    check("wr_no_rd_req", rd_clks, 0);
    check("wr_address", address, exp_addr);
    check("wr_data_out", mux_wdata, exp_wdata);
    check("wr_oe", z80_data_oe, 1'b0);
    release_bus();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_req"}, rd_req, 1'b0);
    check({tag, "_wr_ena"}, wr_ena, 1'b0);
    check({tag, "_oe"}, z80_data_oe, 1'b0);
    check({tag, "_terr"}, timeout_err, 1'b0);
    check({tag, "_wait"}, z80_wait_n, 1'b1);
    check({tag, "_addr"}, address, 20'h0);
    check({tag, "_dout"}, mux_wdata, 8'h00);
    check({tag, "_z80d"}, z80_data_out, 8'h00);
  endtask

  logic [21:0] bnd [4];
  logic [21:0] a;
  int sel;
  int rd_seen;

  initial begin
    bnd[0] = BASE;
    bnd[1] = BASE + SIZE - 22'd1;
    bnd[2] = BASE - 22'd1;
    bnd[3] = BASE + SIZE;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("post_reset");

    // Directed cases
    do_read(22'h0C0010, 8'h5A, 3, 8'hA5, 1'b0, 8'h00, 1'b0);
    do_write(22'h0C7FFF, 8'h3C);
    do_read(22'h0C8000, 8'h77, 3, 8'h99, 1'b0, 8'h00, 1'b0);
    do_read(22'h0C0100, 8'h12, 2, 8'h11, 1'b1, 8'h22, 1'b0);
    do_read(22'h0C0200, 8'h34, 0, 8'h66, 1'b0, 8'h00, 1'b0);
    do_read(22'h0C0300, 8'h56, 14, 8'h42, 1'b0, 8'h00, 1'b0);
    do_read(22'h0C0020, 8'h9C, 3, 8'h81, 1'b0, 8'h00, 1'b1);
    do_read(22'h0C0400, 8'h78, 30, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomised mix
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 5);
      if (sel <= 3) a = BASE + 22'($urandom_range(0, int'(SIZE) - 1));
      else if (sel == 4) a = bnd[$urandom_range(0, 3)];
      else a = 22'($urandom);
      if ($urandom_range(0, 2) == 0)
        do_write(a, 8'($urandom));
      else
        do_read(a, 8'($urandom), $urandom_range(0, 17), 8'($urandom),
                1'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
    end

    // Reset during RD_WAIT
    @(negedge clk);
    z80_addr   = 22'h0C1234;
    z80_mreq_n = 1'b0;
    z80_rd_n   = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 20 && rd_seen == 0; i++) begin
      @(negedge clk);
      if (rd_req) rd_seen = 1;
    end
    check("rst_test_rd_req_seen", rd_seen, 1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    exp_addr = 20'h0; exp_wdata = 8'h00; exp_rdata = 8'h00; exp_terr = 1'b0;
    @(negedge clk);
    z80_mreq_n = 1'b1;
    z80_rd_n   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_req || wr_ena || z80_data_oe) rd_seen++;
    end
    check("idle_after_reset", rd_seen, 0);
    check_reset_values("after_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
